// File: rtl/carregador_programa.sv
// Copies a run of HD tracks into one instruction-memory program slot.
// Optional CARREGADOR_VERIFICA_LIMITE_EN rejects counts larger than TAM_SLOT.
module carregador_programa #(
    parameter int TAM_SLOT = 500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic [4:0]  indiceProgramaIn,
    input  logic [4:0]  setorIn,
    input  logic [15:0] trilhaInicio,
    input  logic [15:0] quantidade,
    input  logic [31:0] hdDadoLido,
    output logic [4:0]  indicePrograma,
    output logic [4:0]  setor,
    output logic [31:0] trilha,
    output logic [15:0] enderecoEscritaMemInstr,
    output logic        hdLeitura,
    output logic        memInstrEscrita,
    output logic [31:0] memInstrDado,
    output logic        ocupado,
    output logic        concluido,
    output logic        erro
);

    typedef enum logic [1:0] {
        OCIOSO,
        LER,
        ESCREVER,
        FIM
    } estado_t;

    estado_t     r_estado;
    estado_t     w_prox;
    logic [4:0]  r_indice;
    logic [4:0]  r_setor;
    logic [15:0] r_trilha_ini;
    logic [15:0] r_qtd;
    logic [15:0] r_cont;
    logic [15:0] r_trilha;
    logic [15:0] r_endereco;
    logic [15:0] w_soma;
    logic [15:0] w_cont_mais;
    logic [15:0] w_trilha;
    logic        w_excede;
    logic        w_aceita;

    assign w_soma      = r_trilha_ini + r_cont;
    assign w_cont_mais = r_cont + 16'd1;

`ifdef CARREGADOR_VERIFICA_LIMITE_EN
    logic r_erro;
    assign w_excede = ({16'd0, quantidade} > 32'(TAM_SLOT));
    assign erro     = r_erro;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_erro <= 1'b0;
        end else begin
            r_erro <= (r_estado == OCIOSO) && iniciar && w_excede;
        end
    end
`else
    assign w_excede = 1'b0;
    assign erro     = 1'b0;
`endif

    assign w_aceita       = (r_estado == OCIOSO) && iniciar && !w_excede;
    assign indicePrograma = r_indice;
    assign setor          = r_setor;
    assign ocupado        = (r_estado != OCIOSO);
    assign trilha         = {16'd0, w_trilha};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado     <= OCIOSO;
            r_indice     <= 5'd0;
            r_setor      <= 5'd0;
            r_trilha_ini <= 16'd0;
            r_qtd        <= 16'd0;
            r_cont       <= 16'd0;
            r_trilha     <= 16'd0;
            r_endereco   <= 16'd0;
        end else begin
            r_estado <= w_prox;
            if (w_aceita) begin
                r_indice     <= indiceProgramaIn;
                r_setor      <= setorIn;
                r_trilha_ini <= trilhaInicio;
                r_qtd        <= quantidade;
                r_cont       <= 16'd0;
            end
            if (r_estado == LER) begin
                r_trilha <= w_soma;
            end
            if (r_estado == ESCREVER) begin
                r_endereco <= r_cont;
                r_cont     <= w_cont_mais;
            end
        end
    end

    // Track and offset hold their last driven value outside LER/ESCREVER.
    always_comb begin
        w_prox                  = r_estado;
        w_trilha                = r_trilha;
        enderecoEscritaMemInstr = r_endereco;
        hdLeitura               = 1'b0;
        memInstrEscrita         = 1'b0;
        memInstrDado            = 32'd0;
        concluido               = 1'b0;
        unique case (r_estado)
            OCIOSO: begin
                if (w_aceita) begin
                    w_prox = (quantidade == 16'd0) ? FIM : LER;
                end
            end
            LER: begin
                hdLeitura = 1'b1;
                w_trilha  = w_soma;
                w_prox    = ESCREVER;
            end
            ESCREVER: begin
                memInstrEscrita         = 1'b1;
                memInstrDado            = hdDadoLido;
                enderecoEscritaMemInstr = r_cont;
                w_prox = (w_cont_mais == r_qtd) ? FIM : LER;
            end
            FIM: begin
                concluido = 1'b1;
                w_prox    = OCIOSO;
            end
            default: w_prox = OCIOSO;
        endcase
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Self-checking bench: cycle-level model of the loader timeline plus
// directed scenarios and randomized transfers.
module tb_carregador_programa;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        iniciar = 1'b0;
    logic [4:0]  indiceProgramaIn = '0;
    logic [4:0]  setorIn = '0;
    logic [15:0] trilhaInicio = '0;
    logic [15:0] quantidade = '0;
    logic [31:0] hdDadoLido = '0;
    logic [4:0]  indicePrograma;
    logic [4:0]  setor;
    logic [31:0] trilha;
    logic [15:0] enderecoEscritaMemInstr;
    logic        hdLeitura;
    logic        memInstrEscrita;
    logic [31:0] memInstrDado;
    logic        ocupado;
    logic        concluido;
    logic        erro;

    carregador_programa dut (
        .clock(clock),
        .reset(reset),
        .iniciar(iniciar),
        .indiceProgramaIn(indiceProgramaIn),
        .setorIn(setorIn),
        .trilhaInicio(trilhaInicio),
        .quantidade(quantidade),
        .hdDadoLido(hdDadoLido),
        .indicePrograma(indicePrograma),
        .setor(setor),
        .trilha(trilha),
        .enderecoEscritaMemInstr(enderecoEscritaMemInstr),
        .hdLeitura(hdLeitura),
        .memInstrEscrita(memInstrEscrita),
        .memInstrDado(memInstrDado),
        .ocupado(ocupado),
        .concluido(concluido),
        .erro(erro)
    );

    always #5 clock = ~clock;

    int nchecks = 0;
    int nerr = 0;
    int wr_cnt = 0;
    int conc_cnt = 0;
    int erro_cnt = 0;
    logic [15:0] last_off = '0;

    // Model: a transfer is a timeline of cycles 1..2N+1 after acceptance.
    bit          m_busy = 0;
    int          m_c = 0;
    int          m_n = 0;
    logic [15:0] m_trk = '0;
    logic [4:0]  m_slot = '0;
    logic [4:0]  m_setor = '0;
    logic [15:0] m_ltrk = '0;
    logic [15:0] m_lend = '0;
    bit          m_erro = 0;

    function automatic bit excede(input logic [15:0] q);
`ifdef CARREGADOR_VERIFICA_LIMITE_EN
        return q > 16'd500;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_c = 0; m_n = 0; m_trk = '0;
            m_slot = '0; m_setor = '0; m_ltrk = '0; m_lend = '0;
            m_erro = 0;
        end else if (!m_busy) begin
            m_erro = iniciar && excede(quantidade);
            if (iniciar && !excede(quantidade)) begin
                m_busy = 1; m_c = 1; m_n = int'(quantidade);
                m_trk = trilhaInicio;
                m_slot = indiceProgramaIn; m_setor = setorIn;
            end
        end else begin
            m_erro = 0;
            if (m_c <= 2 * m_n) begin
                if (m_c % 2 == 1) m_ltrk = m_trk + 16'((m_c - 1) / 2);
                else m_lend = 16'(m_c / 2 - 1);
            end
            if (m_c == 2 * m_n + 1) m_busy = 0;
            else m_c++;
        end
    end

    function automatic logic [95:0] act_vec();
        return {1'b0, indicePrograma, setor, trilha, enderecoEscritaMemInstr,
                hdLeitura, memInstrEscrita, memInstrDado, ocupado,
                concluido, erro};
    endfunction

    function automatic logic [95:0] exp_vec();
        bit rd, wr, cc;
        logic [15:0] t, e;
        rd = m_busy && m_c <= 2 * m_n && m_c % 2 == 1;
        wr = m_busy && m_c <= 2 * m_n && m_c % 2 == 0;
        cc = m_busy && m_c == 2 * m_n + 1;
        t = rd ? m_trk + 16'((m_c - 1) / 2) : m_ltrk;
        e = wr ? 16'(m_c / 2 - 1) : m_lend;
        return {1'b0, m_slot, m_setor, 16'd0, t, e, rd, wr,
                wr ? hdDadoLido : 32'd0, m_busy, cc, m_erro};
    endfunction

    always @(negedge clock) begin
        chk("cycle", act_vec(), exp_vec());
        if (memInstrEscrita) begin
            wr_cnt++;
            last_off = enderecoEscritaMemInstr;
        end
        if (concluido) conc_cnt++;
        if (erro) erro_cnt++;
    end

    always @(posedge clock) begin
        #2 hdDadoLido = $urandom;
    end

    task automatic start(input logic [4:0] sl, input logic [4:0] se,
                         input logic [15:0] tk, input logic [15:0] q);
        @(posedge clock); #2;
        iniciar = 1; indiceProgramaIn = sl; setorIn = se;
        trilhaInicio = tk; quantidade = q;
        @(posedge clock); #2;
        iniciar = 0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (m_busy && t < 5000) begin
            @(posedge clock); #2;
            t++;
        end
        chk("timeout", {95'd0, m_busy}, 96'd0);
    endtask

    task automatic poke();
        @(posedge clock); #2;
        iniciar = 1; indiceProgramaIn = 5'($urandom);
        setorIn = 5'($urandom); trilhaInicio = 16'($urandom);
        quantidade = 16'($urandom % 7);
        @(posedge clock); #2;
        iniciar = 0;
    endtask

    initial begin
        int n0;
        @(negedge clock);
        chk("reset_state", act_vec(), 96'd0);
        @(posedge clock); #2 reset = 1;
        repeat (2) @(posedge clock);

        // slot 2, track 100, 3 words
        start(5'd2, 5'd0, 16'd100, 16'd3);
        @(negedge clock); chk("s1_rd0", {63'd0, hdLeitura, trilha}, {63'd0, 1'b1, 32'd100});
        @(negedge clock); chk("s1_wr0", {79'd0, memInstrEscrita, enderecoEscritaMemInstr}, {79'd0, 1'b1, 16'd0});
        chk("s1_dado0", {64'd0, memInstrDado}, {64'd0, hdDadoLido});
        @(negedge clock); chk("s1_rd1", {63'd0, hdLeitura, trilha}, {63'd0, 1'b1, 32'd101});
        @(negedge clock); chk("s1_wr1", {79'd0, memInstrEscrita, enderecoEscritaMemInstr}, {79'd0, 1'b1, 16'd1});
        @(negedge clock); chk("s1_rd2", {63'd0, hdLeitura, trilha}, {63'd0, 1'b1, 32'd102});
        @(negedge clock); chk("s1_wr2", {79'd0, memInstrEscrita, enderecoEscritaMemInstr}, {79'd0, 1'b1, 16'd2});
        @(negedge clock); chk("s1_conc", {94'd0, concluido, ocupado}, {94'd0, 2'b11});
        @(negedge clock); chk("s1_idle", {94'd0, concluido, ocupado}, 96'd0);
        chk("s1_slot", {91'd0, indicePrograma}, {91'd0, 5'd2});

        // zero count
        n0 = wr_cnt;
        start(5'd1, 5'd1, 16'd7, 16'd0);
        @(negedge clock); chk("s2_conc", {93'd0, concluido, ocupado, hdLeitura}, {93'd0, 3'b110});
        @(negedge clock); chk("s2_idle", {95'd0, ocupado}, 96'd0);
        chk("s2_nowr", 96'(wr_cnt), 96'(n0));

        // track wrap
        start(5'd1, 5'd3, 16'hFFFF, 16'd2);
        @(negedge clock); chk("s3_t0", {64'd0, trilha}, {64'd0, 32'h0000FFFF});
        @(negedge clock);
        @(negedge clock); chk("s3_t1", {64'd0, trilha}, {64'd0, 32'h00000000});
        wait_done();

        // iniciar while busy is ignored
        start(5'd4, 5'd7, 16'd200, 16'd3);
        @(posedge clock); #2;
        iniciar = 1; indiceProgramaIn = 5'd9; setorIn = 5'd1;
        trilhaInicio = 16'd999; quantidade = 16'd1;
        @(posedge clock); #2 iniciar = 0;
        wait_done();
        chk("s4_hold", {48'd0, indicePrograma, setor, trilha[15:0], enderecoEscritaMemInstr},
            {48'd0, 5'd4, 5'd7, 16'd202, 16'd2});

        // reset during ESCREVER of word 1 of 4
        n0 = conc_cnt;
        start(5'd5, 5'd1, 16'd50, 16'd4);
        repeat (4) @(negedge clock);
        #1 reset = 0;
        #1 chk("s5_rst", act_vec(), 96'd0);
        @(posedge clock); #2 reset = 1;
        repeat (10) @(posedge clock);
        chk("s5_noconc", 96'(conc_cnt), 96'(n0));
        n0 = conc_cnt;
        start(5'd6, 5'd2, 16'd10, 16'd2);
        wait_done();
        @(negedge clock);
        chk("s5_again", 96'(conc_cnt), 96'(n0 + 1));

        // randomized transfers
        for (int i = 0; i < 40; i++) begin
            start(5'($urandom), 5'($urandom),
                  ($urandom % 4 == 0) ? 16'hFFFF - 16'($urandom % 3) : 16'($urandom),
                  16'($urandom % 7));
            if ($urandom % 3 == 0) poke();
            wait_done();
            repeat ($urandom % 4) @(posedge clock);
        end

        // overrun / limit
        @(posedge clock); #2;
        wr_cnt = 0; erro_cnt = 0; last_off = '0;
        start(5'd3, 5'd0, 16'd0, 16'd501);
        wait_done();
        repeat (3) @(posedge clock);
`ifdef CARREGADOR_VERIFICA_LIMITE_EN
        chk("s6_nowr", 96'(wr_cnt), 96'd0);
        chk("s6_erro", 96'(erro_cnt), 96'd1);
`else
        chk("s6_wr", 96'(wr_cnt), 96'd501);
        chk("s6_last", {80'd0, last_off}, {80'd0, 16'd500});
        chk("s6_erro", 96'(erro_cnt), 96'd0);
`endif

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
